dec_in: RTL
===========

DEC_IN -- requirements
Module: dec_in

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 9216, giving the number of soft values per LDPC codeword.
REQ-002 SHALL have ports, in order:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- sync_in  in  1  frame start; qualified by en_in, marks sample index 0.
- en_in  in  1  din valid strobe.
- din  in  8  signed two's-complement soft value (LLR).
- dec_done  in  1  one-cycle pulse from decoder; memory banks consumed.
- rom_addr  out  14  permutation ROM address.
- rom_dout  in  14  ROM data {bank[13:8], addr[7:0]}, valid one clock after rom_addr.
- wr_en  out  36  one-hot bank write enable.
- wr_addr  out  8  write address, broadcast to all 36 banks.
- wr_data  out  6  soft value written, broadcast to all banks.
- frame_rdy  out  1  one-cycle pulse, full codeword stored.
- busy  out  1  high while filling or waiting for the decoder.
- ovf  out  1  sticky error, input sample dropped.

Function
REQ-003 SHALL implement states IDLE, FILL, WAIT_DEC.
REQ-004 SHALL, in IDLE, ignore en_in without sync_in; on en_in&&sync_in, accept the sample as index 0 and enter FILL.
REQ-005 SHALL, in FILL, accept each en_in sample at index count, incrementing count 0..FRAME_LEN-1.
REQ-006 SHALL, on en_in&&sync_in in FILL, restart at index 0; already written locations are simply overwritten.
REQ-007 SHALL drive rom_addr combinationally from the index of the sample accepted in the current cycle; otherwise it holds the last value.
REQ-008 SHALL register din and the accept strobe one stage to align with rom_dout.
REQ-009 SHALL, on the following edge, register wr_en[rom_dout[13:8]]=1, wr_addr=rom_dout[7:0] and wr_data=converted din, so writes appear 2 clocks after the accepting edge.
REQ-010 SHALL hold wr_en all-zero and wr_addr/wr_data at 0 in cycles with no write.
REQ-011 SHALL force wr_en to zero when rom_dout[13:8] >= 36 (illegal bank) and set ovf.
REQ-012 SHALL, on acceptance of index FRAME_LEN-1, reset count to 0 and enter WAIT_DEC.
REQ-013 SHALL pulse frame_rdy for one cycle coincident with the last write (index FRAME_LEN-1).
REQ-014 SHALL, in WAIT_DEC, drop every en_in sample (no write) and set ovf for each drop.
REQ-015 SHALL, on dec_done in WAIT_DEC, return to IDLE; a same-cycle en_in&&sync_in SHALL be accepted as index 0 with the state going to FILL.
REQ-016 SHALL ignore dec_done in IDLE and FILL.
REQ-017 SHALL drive busy=1 in FILL and WAIT_DEC, and busy=0 in IDLE.
REQ-018 SHALL clear ovf only on en_in&&sync_in accepted in IDLE, or by reset.

Reset
REQ-019 SHALL, while reset_n=0, asynchronously force state=IDLE, count=0, rom_addr=0, wr_en=0, wr_addr=0, wr_data=0, frame_rdy=0, busy=0, ovf=0, and clear the pipeline valid bit.
REQ-020 SHALL, on reset mid-frame, discard in-flight samples and produce no write after release.

Configuration
REQ-021 SHALL, with DEC_IN_SAT_EN defined, saturate din to 6 bits (>31 -> 31, <-31 -> -31; -32 is never produced).
REQ-022 SHALL, without DEC_IN_SAT_EN, take wr_data=din[5:0] (plain truncation).

Verification
REQ-023 SHALL cover a reset-release frame: 9216 samples, din=index mod 64, ROM identity map -> 9216 one-hot writes at latency 2, frame_rdy once with the last write, busy high throughout.
REQ-024 SHALL cover a ROM entry 0x23FF at index 5 -> wr_en[35]=1, wr_addr=0xFF, 2 clocks after sample 5.
REQ-025 SHALL cover saturation: din=0x7F, 0x80, 0x10 -> wr_data 31, -31, 16 with the macro; 0x3F, 0x00, 0x10 without it.
REQ-026 SHALL cover overflow: 3 samples during WAIT_DEC -> no wr_en, ovf=1; dec_done then sync sample -> ovf=0, index 0 written.
REQ-027 SHALL cover resync: sync_in at index 100 -> that sample written at ROM entry 0, and frame_rdy after 9216 further samples.
REQ-028 SHALL cover reset_n asserted at index 4000 -> all outputs 0 immediately, and no writes until the next sync_in.

Source files
------------

// File: rtl/dec_in.sv
// LDPC decoder input stage: scatters FRAME_LEN soft values into 36 banks via a permutation ROM.
// Optional build macro DEC_IN_SAT_EN saturates din to 6 bits instead of truncating.
module dec_in #(
  parameter int FRAME_LEN = 9216
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sync_in,
  input  logic              en_in,
  input  logic signed [7:0] din,
  input  logic              dec_done,
  output logic [13:0]       rom_addr,
  input  logic [13:0]       rom_dout,
  output logic [35:0]       wr_en,
  output logic [7:0]        wr_addr,
  output logic [5:0]        wr_data,
  output logic              frame_rdy,
  output logic              busy,
  output logic              ovf
);

  localparam logic [13:0] LAST  = 14'(FRAME_LEN - 1);
  localparam logic [5:0]  NBANK = 6'd36;

  typedef enum logic [1:0] {IDLE, FILL, WAIT_DEC} state_t;

  state_t      state, state_nxt;
  logic [13:0] count, count_nxt;
  logic [13:0] idx;
  logic [13:0] rom_addr_q;
  logic        accept;
  logic        drop;

  logic              vld_p0;
  logic              last_p0;
  logic signed [7:0] din_p0;

  logic [5:0] bank;
  logic       bank_ok;

  function automatic logic signed [5:0] conv(input logic signed [7:0] v);
`ifdef DEC_IN_SAT_EN
    // Symmetric range: -32 is never emitted.
    if (v > 8'sd31)
      conv = 6'sd31;
    else if (v < -8'sd31)
      conv = -6'sd31;
    else
      conv = v[5:0];
`else
    conv = v[5:0];
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    drop      = 1'b0;
    idx       = '0;
    case (state)
      IDLE: begin
        if (en_in && sync_in) accept = 1'b1;
      end
      FILL: begin
        if (en_in) begin
          accept = 1'b1;
          idx    = sync_in ? 14'd0 : count;
        end
      end
      WAIT_DEC: begin
        if (en_in && sync_in && dec_done) begin
          accept = 1'b1;
        end else begin
          drop = en_in;
          if (dec_done) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      if (idx == LAST) begin
        state_nxt = WAIT_DEC;
        count_nxt = '0;
      end else begin
        state_nxt = FILL;
        count_nxt = idx + 14'd1;
      end
    end
  end

  // rom_addr follows the accepted index in the same cycle, otherwise holds.
  assign rom_addr = accept ? idx : rom_addr_q;
  assign busy     = (state != IDLE);
  assign bank     = rom_dout[13:8];
  assign bank_ok  = (bank < NBANK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      rom_addr_q <= '0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      rom_addr_q <= rom_addr;
    end
  end

  // Stage p0: align sample with rom_dout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= accept;
      last_p0 <= accept && (idx == LAST);
    end
  end

  always_ff @(posedge clk) begin
    din_p0 <= din;
  end

  // Stage p1: bank write, zeroed when idle or the bank is out of range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_rdy <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (vld_p0 && bank_ok) begin
        wr_en   <= 36'd1 << bank;
        wr_addr <= rom_dout[7:0];
        wr_data <= conv(din_p0);
      end else begin
        wr_en   <= '0;
        wr_addr <= '0;
        wr_data <= '0;
      end
      frame_rdy <= last_p0;
      if (state == IDLE && accept) ovf <= 1'b0;
      if (drop || (vld_p0 && !bank_ok)) ovf <= 1'b1;
    end
  end

endmodule
